// File: rtl/sram_1p_arbiter_pkg.sv
// Purpose: shared constants for the single-port SRAM arbiter and related macro wrappers.
//   - SRAM_DATA_W / SRAM_DEPTH / SRAM_ADDR_W : geometry of the 256x80 hard macro
//   - ST_INIT / ST_RUN                       : controller state encoding
package sram_1p_arbiter_pkg;

  localparam int unsigned SRAM_DATA_W = 80;
  localparam int unsigned SRAM_DEPTH  = 256;
  localparam int unsigned SRAM_ADDR_W = 8;

  localparam int unsigned ST_W = 1;
  localparam logic [ST_W-1:0] ST_INIT = 1'b0;
  localparam logic [ST_W-1:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-way round-robin arbiter with a last-grant pointer.
// Ports:
//   clock   in  clock
//   reset   in  synchronous active-high reset; pointer favours requester 0 next
//   req     in  request per requester
//   advance in  a grant was taken this cycle; update the pointer
//   grant   out one-hot grant, combinational from req and pointer
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Requester that won most recently; reset to 1 so requester 0 wins the first tie.
  logic r_last;

  // Single requester always wins; on a tie the one not granted last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is actually used.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (advance) begin
      r_last <= grant[1];
    end
  end

endmodule

// File: rtl/sram_1p_arbiter.sv
// Purpose: controller for one single-port 256x80 SRAM macro. Zero-fills the array
// after reset, then arbitrates one access per cycle between two requesters and
// returns read data one cycle after the grant, holding the last read word between reads.
// Ports:
//   clock, reset               clock and synchronous active-high reset
//   req_valid/ready/wen        per-requester handshake and direction (1 = write)
//   req_addr/req_wdata         per-requester address / write data, slice i per requester i
//   rsp_valid/rsp_id/rsp_data  read response (no backpressure)
//   init_done                  zero-fill complete
//   sram_ceb/web/a/d/q         macro interface (active-low enables)
module sram_1p_arbiter
  import sram_1p_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = SRAM_DATA_W,
  parameter int unsigned DEPTH  = SRAM_DEPTH,
  parameter int unsigned ADDR_W = SRAM_ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_wen,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                init_done,
  output logic                sram_ceb,
  output logic                sram_web,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_d,
  input  logic [DATA_W-1:0]   sram_q
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_hold;

  logic [1:0]        w_arb_req;
  logic [1:0]        w_grant;
  logic              w_gid;
  logic              w_rd_grant;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (w_arb_req),
    .advance (|w_grant),
    .grant   (w_grant)
  );

  // Next state, arbiter request gating and macro drive. Everything is forced idle
  // while reset is high so the macro never sees a stray access.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_req   = 2'b00;
    w_gid       = w_grant[1];
    w_rd_grant  = 1'b0;
    req_ready   = 2'b00;
    sram_ceb    = 1'b1;
    sram_web    = 1'b1;
    sram_a      = '0;
    sram_d      = '0;
    if (!reset) begin
      case (r_state)
        ST_INIT: begin
          sram_ceb = 1'b0;
          sram_web = 1'b0;
          sram_a   = r_init_cnt;
          if (r_init_cnt == LAST_ADDR) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          w_arb_req = req_valid;
          if (|w_grant) begin
            req_ready  = w_grant;
            sram_ceb   = 1'b0;
            sram_web   = w_gid ? ~req_wen[1] : ~req_wen[0];
            sram_a     = w_gid ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            sram_d     = w_gid ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            w_rd_grant = w_gid ? ~req_wen[1] : ~req_wen[0];
          end
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  // State, init counter, response pipeline and read-hold register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      end
      r_rsp_valid <= w_rd_grant;
      if (w_rd_grant) begin
        r_rsp_id <= w_gid;
      end
      // Capture the returning word so later cycles hide the macro's undefined Q.
      if (r_rsp_valid) begin
        r_hold <= sram_q;
      end
    end
  end

  // Response passes Q through on the return cycle; otherwise shows the held word.
  assign rsp_valid = r_rsp_valid & ~reset;
  assign rsp_id    = r_rsp_id & ~reset;
  assign rsp_data  = reset ? '0 : (r_rsp_valid ? sram_q : r_hold);
  assign init_done = r_init_done & ~reset;

endmodule

// File: tb/tb_sram_1p_arbiter.sv
// Bench for sram_1p_arbiter: behavioural SRAM macro plus a table of per-cycle vectors
// and hand-written reset sequences.
module tb_sram_1p_arbiter;

  localparam int unsigned DW = 80;
  localparam int unsigned AW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_wen;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            init_done;
  logic            sram_ceb;
  logic            sram_web;
  logic [AW-1:0]   sram_a;
  logic [DW-1:0]   sram_d;
  logic [DW-1:0]   sram_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  sram_1p_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .init_done (init_done),
    .sram_ceb  (sram_ceb),
    .sram_web  (sram_web),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // Macro model: one-cycle read latency, random Q on every non-read cycle.
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'({$urandom, $urandom, $urandom});
    sram_q = '0;
  end
  always @(posedge clock) begin
    if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
    if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
    else                       sram_q <= DW'({$urandom, $urandom, $urandom});
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v;
    req_wen   = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Entered just after a negedge with reset low and INIT at count 0; returns at a negedge.
  task automatic zf_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      #2;
      chk($sformatf("zerofill[%0d]", i),
          128'({req_ready, sram_ceb, sram_web, sram_a, sram_d, init_done}),
          128'({2'b00, 1'b0, 1'b0, AW'(i), DW'(0), 1'b0}));
      @(negedge clock);
    end
  endtask

  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    wen;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    e_ready;
    logic          e_ceb;
    logic          e_web;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    logic          e_rv;
    logic          e_rid;
    logic [DW-1:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w, input logic [AW-1:0] a0,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                              input logic [DW-1:0] d1, input logic [1:0] er, input logic ec,
                              input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                              input logic erv, input logic erid, input logic [DW-1:0] erd);
    vec_t t;
    t.valid = v;  t.wen = w;  t.a0 = a0;  t.a1 = a1;  t.d0 = d0;  t.d1 = d1;
    t.e_ready = er;  t.e_ceb = ec;  t.e_web = ew;  t.e_a = ea;  t.e_d = ed;
    t.e_rv = erv;  t.e_rid = erid;  t.e_rdata = erd;
    return t;
  endfunction

  localparam logic [DW-1:0] V  = 80'h1234_5678_9ABC_DEF0_1357;
  localparam logic [DW-1:0] D1 = 80'hAAAA_0000_1111_2222_0001;
  localparam logic [DW-1:0] D2 = 80'hBBBB_3333_4444_5555_0002;
  localparam logic [DW-1:0] FF = 80'hFF;
  localparam logic [DW-1:0] Z  = '0;

  vec_t vt [27];

  initial begin
    // Inputs, expected macro drive this cycle, expected response visible this cycle.
    vt[0]  = mk(2'b11, 2'b00, 8'hA5, 8'hA5, Z,  Z,  2'b01, 0, 1, 8'hA5, Z,  0, 0, Z);
    vt[1]  = mk(2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,  2'b00, 1, 1, 8'h00, Z,  1, 0, Z);
    vt[2]  = mk(2'b01, 2'b01, 8'h10, 8'h00, V,  Z,  2'b01, 0, 0, 8'h10, V,  0, 0, Z);
    vt[3]  = mk(2'b10, 2'b00, 8'h00, 8'h10, Z,  Z,  2'b10, 0, 1, 8'h10, Z,  0, 0, Z);
    vt[4]  = mk(2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,  2'b00, 1, 1, 8'h00, Z,  1, 1, V);
    vt[5]  = mk(2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,  2'b00, 1, 1, 8'h00, Z,  0, 1, V);
    vt[6]  = mk(2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,  2'b00, 1, 1, 8'h00, Z,  0, 1, V);
    vt[7]  = mk(2'b11, 2'b11, 8'h01, 8'h02, D1, D2, 2'b01, 0, 0, 8'h01, D1, 0, 1, V);
    vt[8]  = mk(2'b10, 2'b10, 8'h01, 8'h02, Z,  D2, 2'b10, 0, 0, 8'h02, D2, 0, 1, V);
    vt[9]  = mk(2'b11, 2'b00, 8'h01, 8'h02, Z,  Z,  2'b01, 0, 1, 8'h01, Z,  0, 1, V);
    vt[10] = mk(2'b11, 2'b00, 8'h01, 8'h02, Z,  Z,  2'b10, 0, 1, 8'h02, Z,  1, 0, D1);
    vt[11] = mk(2'b11, 2'b00, 8'h01, 8'h02, Z,  Z,  2'b01, 0, 1, 8'h01, Z,  1, 1, D2);
    vt[12] = mk(2'b11, 2'b00, 8'h01, 8'h02, Z,  Z,  2'b10, 0, 1, 8'h02, Z,  1, 0, D1);
    vt[13] = mk(2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,  2'b00, 1, 1, 8'h00, Z,  1, 1, D2);
    vt[14] = mk(2'b01, 2'b01, 8'h20, 8'h00, FF, Z,  2'b01, 0, 0, 8'h20, FF, 0, 1, D2);
    vt[15] = mk(2'b01, 2'b00, 8'h20, 8'h00, Z,  Z,  2'b01, 0, 1, 8'h20, Z,  0, 1, D2);
    vt[16] = mk(2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,  2'b00, 1, 1, 8'h00, Z,  1, 0, FF);
    for (int i = 17; i < 27; i++)
      vt[i] = mk(2'b00, 2'b00, 8'h00, 8'h00, Z, Z, 2'b00, 1, 1, 8'h00, Z, 0, 0, FF);

    // Reset with both requesters pushing reads of 0xA5.
    reset = 1'b1;
    drive(2'b11, 2'b00, 8'hA5, 8'hA5, Z, Z);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2;
    chk("reset_state",
        128'({req_ready, rsp_valid, rsp_id, rsp_data, init_done, sram_ceb, sram_web, sram_a}),
        128'({2'b00, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b1, 8'h00}));
    chk("reset_sram_d", 128'(sram_d), 128'(Z));
    @(negedge clock);
    reset = 1'b0;

    // Zero-fill: 256 cycles with no grants, then init_done.
    zf_cycles(256);
    #1;
    chk("init_done_257", 128'(init_done), 128'(1'b1));

    for (int i = 0; i < 27; i++) begin
      drive(vt[i].valid, vt[i].wen, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
      #2;
      chk($sformatf("v%0d_ready", i), 128'(req_ready), 128'(vt[i].e_ready));
      chk($sformatf("v%0d_macro", i), 128'({sram_ceb, sram_web, sram_a, sram_d}),
          128'({vt[i].e_ceb, vt[i].e_web, vt[i].e_a, vt[i].e_d}));
      chk($sformatf("v%0d_rsp", i), 128'({rsp_valid, rsp_id, rsp_data}),
          128'({vt[i].e_rv, vt[i].e_rid, vt[i].e_rdata}));
      @(negedge clock);
    end

    // Reset during the cycle a read would return.
    drive(2'b01, 2'b00, 8'hA5, 8'h00, Z, Z);
    #2;
    chk("midread_grant", 128'(req_ready), 128'(2'b01));
    @(negedge clock);
    reset = 1'b1;
    drive(2'b00, 2'b00, 8'h00, 8'h00, Z, Z);
    #2;
    chk("midread_rsp", 128'({rsp_valid, rsp_data}), 128'({1'b0, Z}));
    chk("midread_macro", 128'({sram_ceb, init_done}), 128'({1'b1, 1'b0}));
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midread_restart", 128'({sram_ceb, sram_a, rsp_valid, rsp_data}),
        128'({1'b0, 8'h00, 1'b0, Z}));
    #1;

    // Reset partway through INIT restarts the fill from address 0.
    zf_cycles(100);
    #2;
    chk("midinit_a100", 128'({sram_ceb, sram_a}), 128'({1'b0, 8'd100}));
    reset = 1'b1;
    #1;
    chk("midinit_reset", 128'({sram_ceb, sram_a, req_ready}), 128'({1'b1, 8'h00, 2'b00}));
    @(negedge clock);
    reset = 1'b0;
    zf_cycles(256);
    #1;
    chk("midinit_done", 128'(init_done), 128'(1'b1));
    #1;

    // Address 0x10 was rewritten to zero by the second fill.
    drive(2'b10, 2'b00, 8'h00, 8'h10, Z, Z);
    #2;
    chk("refill_grant", 128'({req_ready, sram_a}), 128'({2'b10, 8'h10}));
    @(negedge clock);
    drive(2'b00, 2'b00, 8'h00, 8'h00, Z, Z);
    #2;
    chk("refill_rsp", 128'({rsp_valid, rsp_id, rsp_data}), 128'({1'b1, 1'b1, Z}));
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_1p_arbiter.md
Name: sram_1p_arbiter

Overview:
Controller and two-requester arbiter for one single-port 256x80 SRAM macro (active-low CEB/WEB, one-cycle read latency, Q undefined on non-read cycles). After reset it zero-fills the array. It then grants one access per cycle between two requesters using round-robin. It returns read data with a fixed one-cycle latency and holds the last read word stable between reads. It sits between the cache/predictor table logic and the hard SRAM macro.

Parameters:
DATA_W, 80, data word width
DEPTH, 256, number of words
ADDR_W, 8, address width; DEPTH must equal 2**ADDR_W

Ports:
clock  in  1  single clock; the macro's CLK is driven from the same net
reset  in  1  reset, synchronous, active-high
req_valid  in  2  request valid, one bit per requester
req_ready  out  2  request accepted when valid and ready are both high in the same cycle
req_wen  in  2  per requester: 1 = write, 0 = read
req_addr  in  2*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W]
req_wdata  in  2*DATA_W  per-requester write data; same slicing as req_addr
rsp_valid  out  1  read data valid this cycle
rsp_id  out  1  requester that issued the returning read
rsp_data  out  DATA_W  read data; held stable after a read returns
init_done  out  1  zero-fill complete
sram_ceb  out  1  macro chip enable, active-low
sram_web  out  1  macro write enable, active-low
sram_a  out  ADDR_W  macro address
sram_d  out  DATA_W  macro write data
sram_q  in  DATA_W  macro read data

Behaviour:
- Reset is synchronous and active-high. While reset is high: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, init_done=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0. The round-robin pointer is set so requester 0 wins the first tie. Any in-flight read is dropped.
- FSM has two states: INIT and RUN. Reset enters INIT with init_cnt=0.
- INIT state:
  - Each cycle drive sram_ceb=0, sram_web=0, sram_a=init_cnt, sram_d=0, then increment init_cnt.
  - req_ready=0 throughout.
  - After the write to DEPTH-1, move to RUN. The zero-fill takes DEPTH cycles.
  - init_done is a register: 0 in INIT, 1 in RUN.
- RUN state:
  - req_ready and the macro drive are combinational from req_valid and the pointer. At most one grant per cycle.
  - With one valid requester, grant it.
  - With both valid, grant the requester that was not granted most recently. The pointer updates only on a grant.
  - On a grant: sram_ceb=0, sram_web=!req_wen[g], sram_a and sram_d taken from the granted requester's slice.
  - With no grant: sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
- Read timing:
  - A read granted in cycle T gives rsp_valid=1 and rsp_id=g in cycle T+1.
  - In that cycle rsp_data = sram_q, passed through combinationally.
  - At the end of T+1, sram_q is captured into a hold register.
  - In every cycle with rsp_valid=0, rsp_data = hold register. This hides the macro's garbage Q.
  - Writes produce no response.
- There is no response backpressure. Requesters must accept rsp_valid when it arrives. Back-to-back reads give rsp_valid high on consecutive cycles.
- Read-after-write to the same address across cycles returns the new data, because the macro serialises the accesses.
- Reset asserted mid-INIT restarts the zero-fill from address 0. Reset asserted mid-RUN drops any pending response: rsp_valid=0 in the cycle after reset.
- A request with req_valid=0 is never granted. req_ready for a non-granted requester is 0.

Decomposition:
- Shared package holds:
  - state encoding constants ST_INIT and ST_RUN
  - SRAM geometry constants (80, 256, 8), shared with other macro wrappers
- One natural sub-module, rr_arb2: the two-way round-robin arbiter with pointer register. Its ports are req[1:0], grant[1:0], advance, clock and reset.
- The INIT counter, macro drive and read-hold path stay in the top module.

Test Plan:
1. Zero-fill: release reset, hold req_valid=2'b11.
   -> req_ready=0 for 256 cycles; sram_a steps 0..255 with sram_web=0 and sram_d=0.
   -> init_done=1 from cycle 257; a subsequent read of address 0xA5 returns 0.
2. Write then read: requester 0 writes addr 0x10, data 80'h1234_5678_9ABC_DEF0_1357; next cycle requester 1 reads 0x10.
   -> one cycle later: rsp_valid=1, rsp_id=1, rsp_data = that value.
   -> rsp_data holds that value on all following idle cycles.
3. Contention: both requesters hold valid reads to 0x01 and 0x02 for 4 cycles.
   -> grants alternate 0,1,0,1 (requester 0 first after reset).
   -> rsp_id sequence 0,1,0,1 with data from 0x01, 0x02, 0x01, 0x02.
4. Hold under idle: read 0x20, containing 80'hFF, then 10 idle cycles while the macro drives random Q.
   -> rsp_data stays 80'hFF; rsp_valid=0 throughout.
5. Reset mid-INIT: assert reset at init_cnt=100 for one cycle.
   -> sram_a restarts at 0; init_done rises 256 cycles after reset deasserts.
6. Reset mid-read: grant a read in cycle T, assert reset in T+1.
   -> rsp_valid=0 and rsp_data=0 in T+1.
   -> after release, INIT restarts with sram_ceb=0 and sram_a=0.
